// File: rtl/ipv4_blacklist_manager_if.sv
// Command/response handshake and filter-table write bus for the IPv4 blacklist manager.
interface ipv4_blacklist_manager_if #(
  parameter int DEPTH = 16,
  parameter int IDX_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [31:0]      cmd_ip;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [1:0]       rsp_status;
  logic [IDX_W-1:0] rsp_index;
  logic             tbl_we;
  logic [IDX_W-1:0] tbl_waddr;
  logic [31:0]      tbl_wdata;
  logic [DEPTH-1:0] tbl_valid_mask;
  logic [IDX_W:0]   entry_count;

  modport master (
    output cmd_valid, cmd_op, cmd_ip, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_status, rsp_index,
    input  tbl_we, tbl_waddr, tbl_wdata, tbl_valid_mask, entry_count
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_ip, rsp_ready,
    output cmd_ready, rsp_valid, rsp_status, rsp_index,
    output tbl_we, tbl_waddr, tbl_wdata, tbl_valid_mask, entry_count
  );
endinterface

// File: rtl/ipv4_blacklist_manager.sv
// Maintains a shadow of the filter address table; add/delete/clear commands are
// resolved by a linear scan and mirrored to the table through a one-cycle write strobe.
module ipv4_blacklist_manager #(
  parameter int DEPTH = 16,
  parameter int IDX_W = 4
) (
  input logic                     i_clk,
  input logic                     i_rst,
  ipv4_blacklist_manager_if.slave bus
);
  // state | meaning
  // IDLE  | waiting for a command, cmd_ready high
  // SCAN  | comparing one shadow entry per cycle
  // WRITE | single table write for add/delete
  // CLEAR | zeroing entries 0..DEPTH-1, one per cycle
  // RESP  | holding the response until rsp_ready
  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_WRITE, S_CLEAR, S_RESP} state_t;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_CLR  = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;
  localparam logic [1:0] ST_OK   = 2'b00;
  localparam logic [1:0] ST_MISS = 2'b01;
  localparam logic [1:0] ST_FULL = 2'b10;
  localparam logic [1:0] ST_BAD  = 2'b11;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_op;
  logic [31:0]      r_ip;
  logic [IDX_W-1:0] r_idx;
  logic             r_found;
  logic [IDX_W-1:0] r_found_idx;
  logic             r_free;
  logic [IDX_W-1:0] r_free_idx;
  logic [1:0]       r_status;
  logic [IDX_W-1:0] r_rsp_idx;
  logic [31:0]      r_mem [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [IDX_W:0]   r_count;

  logic             w_hit, w_last, w_free_now;
  logic             w_set_rsp;
  logic [1:0]       w_rsp_status;
  logic [IDX_W-1:0] w_rsp_idx;
  logic             w_we;
  logic [IDX_W-1:0] w_waddr;
  logic [31:0]      w_wdata;

  assign w_hit      = r_valid[r_idx] && (r_mem[r_idx] == r_ip);
  assign w_last     = (r_idx == LAST_IDX);
  assign w_free_now = r_free || !r_valid[r_idx];

  always_comb begin
    w_state_nxt  = r_state;
    w_set_rsp    = 1'b0;
    w_rsp_status = ST_OK;
    w_rsp_idx    = '0;
    w_we         = 1'b0;
    w_waddr      = '0;
    w_wdata      = '0;
    case (r_state)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          if (bus.cmd_op == OP_RSVD || (bus.cmd_op != OP_CLR && bus.cmd_ip == '0)) begin
            w_state_nxt  = S_RESP;
            w_set_rsp    = 1'b1;
            w_rsp_status = ST_BAD;
          end else if (bus.cmd_op == OP_CLR) begin
            w_state_nxt = S_CLEAR;
          end else begin
            w_state_nxt = S_SCAN;
          end
        end
      end
      S_SCAN: begin
        if (w_hit) begin
          if (r_op == OP_ADD) begin
            w_state_nxt  = S_RESP;
            w_set_rsp    = 1'b1;
            w_rsp_status = ST_MISS;
            w_rsp_idx    = r_idx;
          end else begin
            w_state_nxt = S_WRITE;
          end
        end else if (w_last) begin
          if (r_op == OP_ADD && w_free_now) begin
            w_state_nxt = S_WRITE;
          end else begin
            w_state_nxt  = S_RESP;
            w_set_rsp    = 1'b1;
            w_rsp_status = (r_op == OP_ADD) ? ST_FULL : ST_MISS;
          end
        end
      end
      S_WRITE: begin
        // Only deletes reach WRITE with a match; adds always write the free slot.
        w_we         = 1'b1;
        w_waddr      = r_found ? r_found_idx : r_free_idx;
        w_wdata      = r_found ? 32'd0 : r_ip;
        w_state_nxt  = S_RESP;
        w_set_rsp    = 1'b1;
        w_rsp_idx    = w_waddr;
      end
      S_CLEAR: begin
        w_we    = 1'b1;
        w_waddr = r_idx;
        if (w_last) begin
          w_state_nxt = S_RESP;
          w_set_rsp   = 1'b1;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_op        <= '0;
      r_ip        <= '0;
      r_idx       <= '0;
      r_found     <= 1'b0;
      r_found_idx <= '0;
      r_free      <= 1'b0;
      r_free_idx  <= '0;
      r_status    <= '0;
      r_rsp_idx   <= '0;
      r_valid     <= '0;
      r_count     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_set_rsp) begin
        r_status  <= w_rsp_status;
        r_rsp_idx <= w_rsp_idx;
      end
      case (r_state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            r_op        <= bus.cmd_op;
            r_ip        <= bus.cmd_ip;
            r_idx       <= '0;
            r_found     <= 1'b0;
            r_found_idx <= '0;
            r_free      <= 1'b0;
            r_free_idx  <= '0;
          end
        end
        S_SCAN: begin
          r_idx <= r_idx + 1'b1;
          if (!r_free && !r_valid[r_idx]) begin
            r_free     <= 1'b1;
            r_free_idx <= r_idx;
          end
          if (w_hit) begin
            r_found     <= 1'b1;
            r_found_idx <= r_idx;
          end
        end
        S_WRITE: begin
          r_valid[w_waddr] <= !r_found;
          r_count          <= r_found ? r_count - (IDX_W+1)'(1) : r_count + (IDX_W+1)'(1);
        end
        S_CLEAR: begin
          r_valid[r_idx] <= 1'b0;
          r_idx          <= r_idx + 1'b1;
          if (w_last) r_count <= '0;
        end
        default: ;
      endcase
    end
  end

  // Shadow contents are not reset: the table itself is never written by reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_we) r_mem[w_waddr] <= w_wdata;
  end

  assign bus.cmd_ready      = !i_rst && (r_state == S_IDLE);
  assign bus.rsp_valid      = !i_rst && (r_state == S_RESP);
  assign bus.rsp_status     = bus.rsp_valid ? r_status : 2'b00;
  assign bus.rsp_index      = bus.rsp_valid ? r_rsp_idx : '0;
  assign bus.tbl_we         = !i_rst && w_we;
  assign bus.tbl_waddr      = bus.tbl_we ? w_waddr : '0;
  assign bus.tbl_wdata      = bus.tbl_we ? w_wdata : 32'd0;
  assign bus.tbl_valid_mask = i_rst ? '0 : r_valid;
  assign bus.entry_count    = i_rst ? '0 : r_count;
endmodule

// File: tb/tb_ipv4_blacklist_manager.sv
// Bench for ipv4_blacklist_manager: directed scenarios plus random traffic checked
// against an array-based model of the blacklist.
module tb_ipv4_blacklist_manager;
  localparam int DEPTH = 16;
  localparam int IDX_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ipv4_blacklist_manager_if #(.DEPTH(DEPTH), .IDX_W(IDX_W)) bus ();
  ipv4_blacklist_manager #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] m_ip [DEPTH];
  bit          m_v  [DEPTH];

  typedef struct {
    logic [1:0]  st;
    int          idx;
    int          lat;
    int          nwe;
    int          waddr;
    logic [31:0] wdata;
    int          wcyc;
  } exp_t;

  int             g_lat;
  logic [1:0]     g_st;
  logic [IDX_W-1:0] g_idx;
  bit             g_bad_idle;
  bit             g_unstable;
  int             q_cyc  [$];
  int             q_addr [$];
  logic [31:0]    q_data [$];

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) c += int'(m_v[i]);
    return c;
  endfunction

  function automatic logic [DEPTH-1:0] m_mask();
    logic [DEPTH-1:0] m = '0;
    for (int i = 0; i < DEPTH; i++) m[i] = m_v[i];
    return m;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < DEPTH; i++) m_v[i] = 1'b0;
  endfunction

  // Set-like blacklist model: latency follows from where the scan stops.
  function automatic exp_t model(input logic [1:0] op, input logic [31:0] ip);
    exp_t e;
    int hit;
    int free;
    e = '{st: 2'b00, idx: 0, lat: 0, nwe: 0, waddr: 0, wdata: 32'd0, wcyc: 0};
    hit = -1;
    free = -1;
    for (int i = 0; i < DEPTH; i++) if (hit < 0 && m_v[i] && m_ip[i] == ip) hit = i;
    for (int i = 0; i < DEPTH; i++) if (free < 0 && !m_v[i]) free = i;
    if (op == 2'b11 || (op != 2'b10 && ip == 32'd0)) begin
      e.st = 2'b11; e.lat = 1;
    end else if (op == 2'b10) begin
      e.nwe = DEPTH; e.wcyc = 1; e.lat = DEPTH + 1;
      m_reset();
    end else if (op == 2'b00) begin
      if (hit >= 0) begin
        e.st = 2'b01; e.idx = hit; e.lat = hit + 2;
      end else if (free >= 0) begin
        e.idx = free; e.nwe = 1; e.waddr = free; e.wdata = ip; e.wcyc = DEPTH + 1; e.lat = DEPTH + 2;
        m_v[free] = 1'b1; m_ip[free] = ip;
      end else begin
        e.st = 2'b10; e.lat = DEPTH + 1;
      end
    end else begin
      if (hit >= 0) begin
        e.idx = hit; e.nwe = 1; e.waddr = hit; e.wcyc = hit + 2; e.lat = hit + 3;
        m_v[hit] = 1'b0;
      end else begin
        e.st = 2'b01; e.lat = DEPTH + 1;
      end
    end
    return e;
  endfunction

  function automatic bit m_has(input logic [31:0] ip);
    for (int i = 0; i < DEPTH; i++) if (m_v[i] && m_ip[i] == ip) return 1'b1;
    return 1'b0;
  endfunction

  // Issues one command and records table writes and response timing relative to acceptance.
  task automatic run_cmd(input logic [1:0] op, input logic [31:0] ip, input int hold);
    int t;
    q_cyc.delete(); q_addr.delete(); q_data.delete();
    g_lat = -1; g_bad_idle = 1'b0; g_unstable = 1'b0;
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_ip = ip; bus.rsp_ready = 1'b0;
    t = 0;
    while (!bus.cmd_ready && t < 50) begin @(negedge clk); t++; end
    if (!bus.cmd_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL accept_timeout: cmd_ready=%0b after %0d cycles, required 1", bus.cmd_ready, t);
      bus.cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_ip = 32'd0;
    for (int m = 1; m <= 300; m++) begin
      @(negedge clk);
      if (bus.tbl_we) begin
        q_cyc.push_back(m); q_addr.push_back(int'(bus.tbl_waddr)); q_data.push_back(bus.tbl_wdata);
      end else if (bus.tbl_waddr != '0 || bus.tbl_wdata != 32'd0) g_bad_idle = 1'b1;
      if (bus.rsp_valid) begin
        g_lat = m; g_st = bus.rsp_status; g_idx = bus.rsp_index;
        for (int h = 0; h < hold; h++) begin
          @(negedge clk);
          if (!bus.rsp_valid || bus.rsp_status != g_st || bus.rsp_index != g_idx || bus.cmd_ready)
            g_unstable = 1'b1;
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        break;
      end else if (bus.cmd_ready) g_bad_idle = 1'b1;
    end
    if (g_lat < 0) begin
      n_cmp++; n_fail++;
      $display("FAIL rsp_timeout: no rsp_valid within 300 cycles of acceptance");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_ip = 32'd0; bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({bus.cmd_ready, bus.rsp_valid, bus.tbl_we, bus.tbl_valid_mask, bus.entry_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy=%0b rv=%0b we=%0b mask=%h cnt=%0d, required all 0",
               bus.cmd_ready, bus.rsp_valid, bus.tbl_we, bus.tbl_valid_mask, bus.entry_count);
    end
    rst = 1'b0;
    m_reset();
    #1;
    n_cmp++;
    if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b required 1", bus.cmd_ready); end
    n_cmp++;
    if (bus.tbl_valid_mask !== '0 || bus.entry_count !== '0) begin
      n_fail++; $display("FAIL reset_state: mask=%h cnt=%0d required 0/0", bus.tbl_valid_mask, bus.entry_count);
    end
  endtask

  task automatic test_add_first();
    exp_t e;
    e = model(2'b00, 32'hC0A80001);
    run_cmd(2'b00, 32'hC0A80001, 0);
    n_cmp++;
    if (q_cyc.size() != 1) begin n_fail++; $display("FAIL add_we_count: got %0d required 1", q_cyc.size()); end
    else begin
      n_cmp++;
      if (q_addr[0] != 0 || q_data[0] !== 32'hC0A80001 || q_cyc[0] != DEPTH + 1) begin
        n_fail++; $display("FAIL add_write: addr=%0d data=%h cyc=%0d required 0/c0a80001/%0d", q_addr[0], q_data[0], q_cyc[0], DEPTH + 1);
      end
    end
    n_cmp++;
    if (g_st !== 2'b00 || g_idx !== 4'd0) begin n_fail++; $display("FAIL add_rsp: st=%0d idx=%0d required 0/0", g_st, g_idx); end
    n_cmp++;
    if (g_lat != DEPTH + 2 || g_lat != e.lat) begin n_fail++; $display("FAIL add_latency: got %0d required %0d", g_lat, DEPTH + 2); end
    n_cmp++;
    if (bus.entry_count !== 5'd1) begin n_fail++; $display("FAIL add_count: got %0d required 1", bus.entry_count); end
  endtask

  task automatic test_dup();
    exp_t e;
    e = model(2'b00, 32'hC0A80001);
    run_cmd(2'b00, 32'hC0A80001, 0);
    n_cmp++;
    if (q_cyc.size() != 0) begin n_fail++; $display("FAIL dup_no_write: got %0d writes required 0", q_cyc.size()); end
    n_cmp++;
    if (g_st !== 2'b01 || g_idx !== 4'd0 || g_lat != e.lat) begin
      n_fail++; $display("FAIL dup_rsp: st=%0d idx=%0d lat=%0d required 1/0/%0d", g_st, g_idx, g_lat, e.lat);
    end
    n_cmp++;
    if (bus.entry_count !== 5'd1) begin n_fail++; $display("FAIL dup_count: got %0d required 1", bus.entry_count); end
  endtask

  task automatic test_full_delete();
    exp_t e;
    logic [31:0] ip;
    logic [31:0] victim;
    while (m_count() < DEPTH) begin
      ip = $urandom();
      if (ip == 32'd0 || ip == 32'h0A000001 || m_has(ip)) continue;
      e = model(2'b00, ip);
      run_cmd(2'b00, ip, 0);
      n_cmp++;
      if (g_st !== 2'b00 || int'(g_idx) != e.idx) begin
        n_fail++; $display("FAIL fill_rsp: st=%0d idx=%0d required 0/%0d", g_st, g_idx, e.idx);
      end
    end
    e = model(2'b00, 32'h0A000001);
    run_cmd(2'b00, 32'h0A000001, 0);
    n_cmp++;
    if (g_st !== 2'b10 || g_idx !== 4'd0 || q_cyc.size() != 0 || g_lat != DEPTH + 1) begin
      n_fail++; $display("FAIL full_rsp: st=%0d idx=%0d writes=%0d lat=%0d required 2/0/0/%0d", g_st, g_idx, q_cyc.size(), g_lat, DEPTH + 1);
    end
    victim = m_ip[5];
    e = model(2'b01, victim);
    run_cmd(2'b01, victim, 0);
    n_cmp++;
    if (q_cyc.size() != 1) begin n_fail++; $display("FAIL del_we_count: got %0d required 1", q_cyc.size()); end
    else begin
      n_cmp++;
      if (q_addr[0] != 5 || q_data[0] !== 32'd0 || q_cyc[0] != 7) begin
        n_fail++; $display("FAIL del_write: addr=%0d data=%h cyc=%0d required 5/0/7", q_addr[0], q_data[0], q_cyc[0]);
      end
    end
    n_cmp++;
    if (g_st !== 2'b00 || g_idx !== 4'd5 || g_lat != 8 || bus.entry_count !== 5'd15) begin
      n_fail++; $display("FAIL del_rsp: st=%0d idx=%0d lat=%0d cnt=%0d required 0/5/8/15", g_st, g_idx, g_lat, bus.entry_count);
    end
    e = model(2'b00, 32'h0A000001);
    run_cmd(2'b00, 32'h0A000001, 0);
    n_cmp++;
    if (q_cyc.size() != 1 || g_idx !== 4'd5 || g_st !== 2'b00) begin
      n_fail++; $display("FAIL refill: writes=%0d st=%0d idx=%0d required 1/0/5", q_cyc.size(), g_st, g_idx);
    end else begin
      n_cmp++;
      if (q_addr[0] != 5 || q_data[0] !== 32'h0A000001) begin
        n_fail++; $display("FAIL refill_write: addr=%0d data=%h required 5/0a000001", q_addr[0], q_data[0]);
      end
    end
  endtask

  task automatic test_badcmd();
    exp_t e;
    int cnt;
    cnt = m_count();
    e = model(2'b01, 32'h08080808);
    run_cmd(2'b01, 32'h08080808, 0);
    n_cmp++;
    if (g_st !== 2'b01 || g_idx !== 4'd0 || q_cyc.size() != 0 || g_lat != e.lat) begin
      n_fail++; $display("FAIL notfound: st=%0d idx=%0d writes=%0d lat=%0d required 1/0/0/%0d", g_st, g_idx, q_cyc.size(), g_lat, e.lat);
    end
    e = model(2'b00, 32'd0);
    run_cmd(2'b00, 32'd0, 0);
    n_cmp++;
    if (g_st !== 2'b11 || g_idx !== 4'd0 || g_lat != 1) begin
      n_fail++; $display("FAIL bad_ip0: st=%0d idx=%0d lat=%0d required 3/0/1", g_st, g_idx, g_lat);
    end
    e = model(2'b11, 32'h01020304);
    run_cmd(2'b11, 32'h01020304, 0);
    n_cmp++;
    if (g_st !== 2'b11 || g_lat != 1 || q_cyc.size() != 0) begin
      n_fail++; $display("FAIL bad_op3: st=%0d lat=%0d writes=%0d required 3/1/0", g_st, g_lat, q_cyc.size());
    end
    n_cmp++;
    if (int'(bus.entry_count) != cnt) begin n_fail++; $display("FAIL bad_count: got %0d required %0d", bus.entry_count, cnt); end
  endtask

  task automatic test_clear();
    exp_t e;
    bit seq_ok;
    e = model(2'b10, 32'd0);
    run_cmd(2'b10, 32'd0, 0);
    for (int i = 0; i < 3; i++) begin
      e = model(2'b00, 32'h0B000000 + i + 1);
      run_cmd(2'b00, 32'h0B000000 + i + 1, 0);
    end
    n_cmp++;
    if (bus.entry_count !== 5'd3) begin n_fail++; $display("FAIL clear_pre_count: got %0d required 3", bus.entry_count); end
    e = model(2'b10, 32'hFFFFFFFF);
    run_cmd(2'b10, 32'hFFFFFFFF, 0);
    n_cmp++;
    if (q_cyc.size() != DEPTH) begin n_fail++; $display("FAIL clear_we_count: got %0d required %0d", q_cyc.size(), DEPTH); end
    else begin
      seq_ok = 1'b1;
      foreach (q_cyc[i]) if (q_cyc[i] != i + 1 || q_addr[i] != i || q_data[i] !== 32'd0) seq_ok = 1'b0;
      n_cmp++;
      if (!seq_ok) begin n_fail++; $display("FAIL clear_sequence: writes not consecutive 0..%0d with data 0", DEPTH - 1); end
    end
    n_cmp++;
    if (g_st !== 2'b00 || g_idx !== 4'd0 || g_lat != e.lat) begin
      n_fail++; $display("FAIL clear_rsp: st=%0d idx=%0d lat=%0d required 0/0/%0d", g_st, g_idx, g_lat, e.lat);
    end
    n_cmp++;
    if (bus.tbl_valid_mask !== '0 || bus.entry_count !== '0) begin
      n_fail++; $display("FAIL clear_state: mask=%h cnt=%0d required 0/0", bus.tbl_valid_mask, bus.entry_count);
    end
  endtask

  task automatic test_stall();
    exp_t e;
    e = model(2'b00, 32'h0C0C0C0C);
    run_cmd(2'b00, 32'h0C0C0C0C, 10);
    n_cmp++;
    if (g_unstable) begin n_fail++; $display("FAIL stall_stable: response changed or cmd_ready high while rsp_ready low"); end
    n_cmp++;
    if (g_st !== e.st || int'(g_idx) != e.idx) begin
      n_fail++; $display("FAIL stall_rsp: st=%0d idx=%0d required %0d/%0d", g_st, g_idx, e.st, e.idx);
    end
  endtask

  task automatic test_reset_midscan();
    bit seen;
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'b00; bus.cmd_ip = 32'h0D0D0D0D; bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.cmd_ready, bus.rsp_valid, bus.tbl_we, bus.tbl_valid_mask, bus.entry_count} !== '0) begin
      n_fail++; $display("FAIL midscan_rst_outputs: rdy=%0b rv=%0b we=%0b mask=%h cnt=%0d required all 0",
                         bus.cmd_ready, bus.rsp_valid, bus.tbl_we, bus.tbl_valid_mask, bus.entry_count);
    end
    rst = 1'b0;
    m_reset();
    #1;
    n_cmp++;
    if (bus.cmd_ready !== 1'b1 || bus.tbl_valid_mask !== '0) begin
      n_fail++; $display("FAIL midscan_idle: rdy=%0b mask=%h required 1/0", bus.cmd_ready, bus.tbl_valid_mask);
    end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.tbl_we || bus.rsp_valid || !bus.cmd_ready) seen = 1'b1;
    end
    bus.rsp_ready = 1'b0;
    n_cmp++;
    if (seen) begin n_fail++; $display("FAIL midscan_quiet: write, response or busy seen after reset, required none"); end
  endtask

  task automatic test_random();
    exp_t e;
    logic [31:0] pool [20];
    logic [1:0] op;
    logic [31:0] ip;
    int r;
    for (int i = 0; i < 20; i++) pool[i] = 32'hAC100000 + 32'(i * 7 + 1);
    for (int n = 0; n < 70; n++) begin
      r = int'($urandom_range(0, 99));
      op = (r < 55) ? 2'b00 : (r < 90) ? 2'b01 : (r < 95) ? 2'b10 : 2'b11;
      ip = ($urandom_range(0, 19) == 0) ? 32'd0 : pool[$urandom_range(0, 19)];
      e = model(op, ip);
      run_cmd(op, ip, int'($urandom_range(0, 2)));
      n_cmp++;
      if (g_st !== e.st || int'(g_idx) != e.idx || g_lat != e.lat) begin
        n_fail++; $display("FAIL rand_rsp[%0d]: st=%0d idx=%0d lat=%0d required %0d/%0d/%0d",
                           n, g_st, g_idx, g_lat, e.st, e.idx, e.lat);
      end
      n_cmp++;
      if (q_cyc.size() != e.nwe) begin n_fail++; $display("FAIL rand_we_count[%0d]: got %0d required %0d", n, q_cyc.size(), e.nwe); end
      else if (e.nwe > 0) begin
        n_cmp++;
        if (q_addr[0] != e.waddr || q_data[0] !== e.wdata || q_cyc[0] != e.wcyc) begin
          n_fail++; $display("FAIL rand_write[%0d]: addr=%0d data=%h cyc=%0d required %0d/%h/%0d",
                             n, q_addr[0], q_data[0], q_cyc[0], e.waddr, e.wdata, e.wcyc);
        end
      end
      n_cmp++;
      if (bus.tbl_valid_mask !== m_mask() || int'(bus.entry_count) != m_count() || g_bad_idle) begin
        n_fail++; $display("FAIL rand_state[%0d]: mask=%h cnt=%0d idle_bad=%0b required %h/%0d/0",
                           n, bus.tbl_valid_mask, bus.entry_count, g_bad_idle, m_mask(), m_count());
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_first();
    test_dup();
    test_full_delete();
    test_badcmd();
    test_clear();
    test_stall();
    test_reset_midscan();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/ipv4_blacklist_manager.md
IPV4_BLACKLIST_MANAGER -- requirements
Module: ipv4_blacklist_manager

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of blacklist entries (power of two, 2..256).
REQ-002 SHALL have parameter IDX_W, default 4, entry index width, equal to log2(DEPTH).
REQ-003 SHALL have clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have cmd_valid  input  1  command present.
REQ-006 SHALL have cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high at a rising edge.
REQ-007 SHALL have cmd_op  input  2  00 add, 01 delete, 10 clear-all, 11 reserved.
REQ-008 SHALL have cmd_ip  input  32  IPv4 address operand (ignored for clear-all).
REQ-009 SHALL have rsp_valid  output  1  response present; held until accepted.
REQ-010 SHALL have rsp_ready  input  1  response accepted when rsp_valid and rsp_ready are both high at a rising edge.
REQ-011 SHALL have rsp_status  output  2  00 OK, 01 DUP/NOTFOUND, 10 FULL, 11 BADCMD.
REQ-012 SHALL have rsp_index  output  IDX_W  entry index affected or matched; 0 when not applicable.
REQ-013 SHALL have tbl_we  output  1  one-cycle write strobe to the filter address table.
REQ-014 SHALL have tbl_waddr  output  IDX_W  table write address.
REQ-015 SHALL have tbl_wdata  output  32  table write data.
REQ-016 SHALL have tbl_valid_mask  output  DEPTH  per-entry valid bits; the filter gates matches with these bits.
REQ-017 SHALL have entry_count  output  IDX_W+1  number of valid entries, 0..DEPTH.

Function
REQ-018 SHALL keep a shadow copy of all DEPTH entries plus the valid bits, and SHALL keep the shadow copy identical to what has been written to the table.
REQ-019 SHALL implement the states IDLE, SCAN, WRITE, CLEAR and RESP.
REQ-020 SHALL drive cmd_ready high only in IDLE and SHALL accept at most one command per response.
REQ-021 IDLE, on acceptance: SHALL latch cmd_op and cmd_ip and clear the scan index, found flag and free flag.
REQ-022 IDLE, on acceptance, SHALL branch as follows: op 11, or cmd_ip==0 with add/delete, goes to RESP with BADCMD; op 10 goes to CLEAR; otherwise goes to SCAN.
REQ-023 SCAN SHALL examine one entry per cycle, from index 0 upward.
REQ-024 SCAN: a valid entry equal to the latched IP SHALL set found and its index, then end the scan at once.
REQ-025 SCAN: the first invalid entry SHALL be recorded as the free slot (lowest index wins).
REQ-026 SCAN SHALL otherwise end after examining index DEPTH-1.
REQ-027 Scan result for add: found goes to RESP with DUP and the matched index; not found with a free slot goes to WRITE; not found with no free slot goes to RESP with FULL and index 0.
REQ-028 Scan result for delete: found goes to WRITE; not found goes to RESP with NOTFOUND and index 0.
REQ-029 WRITE SHALL last exactly one cycle with tbl_we=1.
REQ-030 WRITE for add SHALL set tbl_waddr to the free slot, tbl_wdata to the IP, set the valid bit and increment entry_count.
REQ-031 WRITE for delete SHALL set tbl_waddr to the matched index, tbl_wdata to 0, clear the valid bit and decrement entry_count.
REQ-032 WRITE SHALL then go to RESP with OK and the written index.
REQ-033 CLEAR SHALL write 0 to every entry in index order 0..DEPTH-1, one per cycle with tbl_we=1, clearing each valid bit as it is written.
REQ-034 CLEAR SHALL set entry_count to 0 on the last write cycle, then go to RESP with OK and index 0.
REQ-035 RESP SHALL hold rsp_valid, rsp_status and rsp_index stable until rsp_ready is sampled high, then return to IDLE.
REQ-036 rsp_valid SHALL be 0 in every state other than RESP.
REQ-037 tbl_we SHALL be 0 outside WRITE and CLEAR; tbl_waddr and tbl_wdata SHALL be 0 when tbl_we=0.
REQ-038 entry_count SHALL never exceed DEPTH and SHALL never go below 0.
REQ-039 Latency for add with no match SHALL be: acceptance at edge E; SCAN DEPTH cycles; WRITE at cycle E+DEPTH+1; rsp_valid high from cycle E+DEPTH+2.
REQ-040 Latency for delete matching index k SHALL be: WRITE at E+k+2; rsp_valid from E+k+3.
REQ-041 A BADCMD response SHALL have rsp_valid high from cycle E+1.

Reset
REQ-042 rst high at an edge SHALL force IDLE and clear all valid bits, entry_count, the latched command, the flags and the index, regardless of the current state, including mid-SCAN, mid-CLEAR and during RESP.
REQ-043 During a cycle with rst high, all outputs SHALL be 0, including cmd_ready; cmd_ready SHALL be 1 from the first cycle after rst deasserts.
REQ-044 Reset SHALL not write the table; a partially completed CLEAR or WRITE SHALL not be retried.

Verification
REQ-045 Bench SHALL cover: reset, add 0xC0A80001 with rsp_ready=1 -> tbl_we at waddr 0, wdata 0xC0A80001; OK, index 0; entry_count 1; rsp_valid DEPTH+2 cycles after acceptance.
REQ-046 Bench SHALL cover: add 0xC0A80001 again -> no tbl_we; DUP, index 0; entry_count unchanged.
REQ-047 Bench SHALL cover: fill 16 distinct IPs, then add 0x0A000001 -> FULL, index 0; then delete the IP at index 5 -> tbl_we waddr 5, wdata 0; OK, index 5; count 15; then add 0x0A000001 -> written at index 5.
REQ-048 Bench SHALL cover: delete 0x08080808 when absent -> NOTFOUND; add IP 0 -> BADCMD at E+1; op 11 -> BADCMD.
REQ-049 Bench SHALL cover: clear-all with 3 entries valid -> 16 consecutive tbl_we cycles, addresses 0..15, data 0; mask all 0; count 0; OK.
REQ-050 Bench SHALL cover: rsp_ready held low 10 cycles -> rsp_valid and rsp fields stable and cmd_ready low; rst asserted mid-SCAN -> next cycle IDLE, mask 0, no tbl_we, no response.
